// File: rtl/dwconv_pkg.sv
// Shared types and defaults for the depthwise-conv stage controllers.
package dwconv_pkg;

   localparam int unsigned CNT_W     = 5;
   localparam int unsigned POS_W     = 4;
   localparam int unsigned N_CNT_DEF = 32;
   localparam int unsigned N_POS_DEF = 9;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/dwconv_valid_pipe.sv
// Enable-gated valid/last shadow of a fixed-latency pipeline.
module dwconv_valid_pipe #(
   parameter int unsigned LAT = 2
) (
   input  logic clk,
   input  logic rst_b,
   input  logic en_i,
   input  logic vld_i,
   input  logic last_i,
   output logic vld_o,
   output logic last_o
);

   logic [LAT-1:0] vld_q;
   logic [LAT-1:0] last_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         vld_q  <= '0;
         last_q <= '0;
      end else if (en_i) begin
         vld_q[0]  <= vld_i;
         last_q[0] <= last_i;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            last_q[i] <= last_q[i-1];
         end
      end
   end

   assign vld_o  = vld_q[LAT-1];
   assign last_o = last_q[LAT-1];

endmodule

// File: rtl/dwconv_seq_ctrl.sv
// Tile sequencer for the DW rescale/ReLU pipeline (tags, en, valid tracking).
// Optional perf counters: define DWCONV_SEQ_PERF_EN.
module dwconv_seq_ctrl
   import dwconv_pkg::*;
#(
   parameter int unsigned LAT   = 2,
   parameter int unsigned N_CNT = N_CNT_DEF,
   parameter int unsigned N_POS = N_POS_DEF
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             pipe_en,
   output logic [CNT_W-1:0] cnt_tag,
   output logic [POS_W-1:0] pos_tag,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef DWCONV_SEQ_PERF_EN
   output logic [15:0]      stall_cycles,
   output logic [15:0]      bubble_cycles,
`endif
   output logic             out_last
);

   seq_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [POS_W-1:0] pos_q;
   logic             busy_q;
   logic             done_q;
   logic             stall;
   logic             acc;
   logic             cnt_max;
   logic             last_beat;

   assign stall     = out_valid && !out_ready;
   assign pipe_en   = !stall;
   assign in_ready  = (state_q == S_RUN) && pipe_en;
   assign acc       = in_valid && in_ready;
   assign cnt_max   = (cnt_q == CNT_W'(N_CNT - 1));
   assign last_beat = cnt_max && (pos_q == POS_W'(N_POS - 1));

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pos_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               pos_q <= '0;
               if (start) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (acc) begin
                  if (last_beat) begin
                     cnt_q   <= '0;
                     pos_q   <= '0;
                     state_q <= S_DRAIN;
                  end else if (cnt_max) begin
                     cnt_q <= '0;
                     pos_q <= pos_q + POS_W'(1);
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (out_valid && out_ready && out_last) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign cnt_tag = cnt_q;
   assign pos_tag = pos_q;

   dwconv_valid_pipe #(
      .LAT (LAT)
   ) u_vpipe (
      .clk    (clk),
      .rst_b  (rst_b),
      .en_i   (pipe_en),
      .vld_i  (acc),
      .last_i (acc && last_beat),
      .vld_o  (out_valid),
      .last_o (out_last)
   );

`ifdef DWCONV_SEQ_PERF_EN
   logic [15:0] stall_q;
   logic [15:0] bubble_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else if (state_q == S_IDLE && start) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (stall && busy_q && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
         if (state_q == S_RUN && !in_valid && bubble_q != 16'hFFFF)
            bubble_q <= bubble_q + 16'd1;
      end
   end

   assign stall_cycles  = stall_q;
   assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_dwconv_seq_ctrl.sv
// Randomized scoreboard bench for dwconv_seq_ctrl.
// Perf counters are checked when DWCONV_SEQ_PERF_EN is defined.
module tb_dwconv_seq_ctrl;

   localparam int LAT   = 2;
   localparam int NC    = 32;
   localparam int NP    = 9;
   localparam int BEATS = NC * NP;

   logic       clk = 1'b0;
   logic       rst_b;
   logic       start;
   logic       busy;
   logic       done;
   logic       in_valid;
   logic       in_ready;
   logic       pipe_en;
   logic [4:0] cnt_tag;
   logic [3:0] pos_tag;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
`ifdef DWCONV_SEQ_PERF_EN
   logic [15:0] stall_cycles;
   logic [15:0] bubble_cycles;
`endif

   dwconv_seq_ctrl #(.LAT(LAT), .N_CNT(NC), .N_POS(NP)) dut (
      .clk           (clk),
      .rst_b         (rst_b),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .pipe_en       (pipe_en),
      .cnt_tag       (cnt_tag),
      .pos_tag       (pos_tag),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
`ifdef DWCONV_SEQ_PERF_EN
      .stall_cycles  (stall_cycles),
      .bubble_cycles (bubble_cycles),
`endif
      .out_last      (out_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int k_edge = 0;
   int lat_chk = 0;
   int acc_n = 0;
   int outs = 0;
   int dones = 0;
   int stl_m = 0;
   int bub_m = 0;
   bit sbq[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // input side: tags vs. raster-order model, push expected last flag
   always @(negedge clk) begin
      if (rst_b) begin
         if (!busy) begin
            chk("idle_cnt_tag", int'(cnt_tag), 0);
            chk("idle_pos_tag", int'(pos_tag), 0);
         end else if (acc_n < BEATS) begin
            chk("cnt_tag", int'(cnt_tag), acc_n % NC);
            chk("pos_tag", int'(pos_tag), acc_n / NC);
            if (!in_valid) bub_m++;
         end
         if (out_valid && !out_ready) begin
            chk("stall_pipe_en", int'(pipe_en), 0);
            chk("stall_in_ready", int'(in_ready), 0);
            if (busy) stl_m++;
         end else begin
            chk("pipe_en", int'(pipe_en), 1);
         end
         if (in_valid && in_ready) begin
            chk("accept_in_range", int'(acc_n < BEATS), 1);
            sbq.push_back(acc_n == BEATS - 1);
            acc_n++;
         end
      end
   end

   // output side: pop and compare
   always @(negedge clk) begin
      if (rst_b) begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("out_unexpected_beat", outs, -1);
            end else begin
               chk("out_last", int'(out_last), int'(sbq.pop_front()));
            end
            outs++;
         end
         if (done) begin
            dones++;
            if (lat_chk != 0) chk("done_cycle", cyc, k_edge + BEATS + LAT);
         end
      end
   end

   task automatic chk_reset_vals();
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_pipe_en", int'(pipe_en), 1);
      chk("rst_cnt_tag", int'(cnt_tag), 0);
      chk("rst_pos_tag", int'(pos_tag), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_last", int'(out_last), 0);
   endtask

   // mode: 0 nominal, 1 backpressure, 2 bubbles, 3 start while busy,
   //       4 random, 5 reset mid-tile
   task automatic run_tile(input int mode);
      bit fin;
      acc_n = 0;
      outs  = 0;
      dones = 0;
      stl_m = 0;
      bub_m = 0;
      sbq.delete();
      lat_chk = (mode == 0);
      start = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      k_edge = cyc + 1;
      @(posedge clk);
      #1;
      start = 1'b0;
      fin = 1'b0;
      for (int t = 0; t < 4000; t++) begin
         if (mode == 5 && t == 150) begin
            rst_b = 1'b0;
            #1;
            chk_reset_vals();
            sbq.delete();
            acc_n = 0;
            @(posedge clk);
            #1;
            rst_b = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            chk("reset_no_done", dones, 0);
            chk("reset_idle_busy", int'(busy), 0);
            return;
         end
         case (mode)
            1: begin
               in_valid  = 1'b1;
               out_ready = !(t >= 110 && t < 115);
            end
            2: begin
               in_valid  = t[0];
               out_ready = 1'b1;
            end
            3: begin
               in_valid  = 1'b1;
               out_ready = 1'b1;
               start     = (acc_n == 100);
            end
            4: begin
               in_valid  = ($urandom_range(0, 3) != 0);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            default: begin
               in_valid  = 1'b1;
               out_ready = 1'b1;
            end
         endcase
         @(posedge clk);
         #1;
         start = 1'b0;
         if (dones != 0) begin
            fin = 1'b1;
            break;
         end
      end
      chk("tile_timeout", int'(fin), 1);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("done_pulses", dones, 1);
      chk("accepted_beats", acc_n, BEATS);
      chk("output_beats", outs, BEATS);
      chk("sb_empty", sbq.size(), 0);
`ifdef DWCONV_SEQ_PERF_EN
      chk("stall_cycles", int'(stall_cycles), stl_m);
      chk("bubble_cycles", int'(bubble_cycles), bub_m);
      if (mode == 1) chk("stall_cycles_bp", int'(stall_cycles), 5);
      if (mode == 0) chk("bubble_cycles_nom", int'(bubble_cycles), 0);
`endif
   endtask

   initial begin
      rst_b     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals();
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      run_tile(0);
      run_tile(1);
      run_tile(2);
      run_tile(3);
      run_tile(5);
      run_tile(0);
      for (int i = 0; i < 3; i++) run_tile(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
